// File: rtl/snake_pkg.sv
// Shared snake-game definitions: placer FSM states and grid constants.
package snake_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DRAW,
        SCAN,
        DONE
    } state_t;

    localparam int CELL_COUNT = 1000;
    localparam int INIT_FOOD  = 300;

endpackage

// File: rtl/food_placer.sv
// Food placer: draws LFSR candidates, rejects off-grid/forbidden/body cells.
// FOOD_PLACER_PROBE_EN: after MAX_TRIES rejections, probe linearly from cand.
module food_placer
    import snake_pkg::*;
#(
    parameter int max_len         = 16,
    parameter int num_len         = 10,
    parameter int max_len_bit_len = 4,
    parameter int CELL_COUNT      = snake_pkg::CELL_COUNT,
    parameter logic [num_len-1:0] INIT_FOOD = num_len'(snake_pkg::INIT_FOOD),
    parameter int MAX_TRIES       = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       req,
    input  logic [num_len-1:0]         rand_in,
    input  logic [num_len-1:0]         other_food,
    input  logic [max_len_bit_len-1:0] snake_len,
    output logic [max_len_bit_len-1:0] body_idx,
    input  logic [num_len-1:0]         body_pos,
    output logic                       busy,
    output logic                       food_valid,
    output logic [num_len-1:0]         food_pos
);

    localparam int TW = $clog2(MAX_TRIES + 1);
    localparam logic [TW-1:0] TRIES_MAX = TW'(MAX_TRIES);
    localparam logic [num_len-1:0] LAST = num_len'(CELL_COUNT - 1);
    localparam logic [max_len_bit_len-1:0] LEN_MAX =
        max_len_bit_len'(max_len - 1);
    localparam logic [max_len_bit_len-1:0] ONE = max_len_bit_len'(1);

    state_t                     state_q, state_d;
    logic [num_len-1:0]         cand_q, cand_d;
    logic [num_len-1:0]         other_q, other_d;
    logic [max_len_bit_len-1:0] len_q, len_d;
    logic [max_len_bit_len-1:0] idx_q, idx_d;
    logic [TW-1:0]              tries_q, tries_d;
    logic [num_len-1:0]         pick;
    logic                       reject;

    always_comb begin
        state_d = state_q;
        cand_d  = cand_q;
        other_d = other_q;
        len_d   = len_q;
        idx_d   = idx_q;
        tries_d = tries_q;
        pick    = rand_in;
        reject  = 1'b0;
        unique case (state_q)
            IDLE: begin
                tries_d = '0;
                idx_d   = '0;
                if (req) begin
                    state_d = DRAW;
                    len_d   = (snake_len > LEN_MAX) ? LEN_MAX : snake_len;
                    other_d = other_food;
                end
            end
            DRAW: begin
`ifdef FOOD_PLACER_PROBE_EN
                if (tries_q == TRIES_MAX)
                    pick = (cand_q >= LAST) ? '0 : cand_q + 1'b1;
`endif
                cand_d = pick;
                idx_d  = '0;
                if (pick > LAST || pick == other_q)
                    reject = 1'b1;
                else if (len_q == '0)
                    state_d = DONE;
                else
                    state_d = SCAN;
            end
            SCAN: begin
                if (body_pos == cand_q) begin
                    reject  = 1'b1;
                    state_d = DRAW;
                    idx_d   = '0;
                end else if (idx_q == len_q - ONE) begin
                    state_d = DONE;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + ONE;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (reject && tries_q != TRIES_MAX)
            tries_d = tries_q + 1'b1;
    end

    // food_pos takes the winner on entry to DONE so it is new during DONE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cand_q   <= '0;
            other_q  <= '0;
            len_q    <= '0;
            idx_q    <= '0;
            tries_q  <= '0;
            food_pos <= INIT_FOOD;
        end else begin
            state_q <= state_d;
            cand_q  <= cand_d;
            other_q <= other_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            tries_q <= tries_d;
            if (state_d == DONE)
                food_pos <= cand_d;
        end
    end

    assign body_idx   = idx_q;
    assign busy       = (state_q != IDLE);
    assign food_valid = (state_q == DONE);

endmodule

// File: tb/tb_food_placer.sv
// Directed testbench for food_placer with a small body-store model.
module tb_food_placer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req = 1'b0;
    logic [9:0] rand_in = '0;
    logic [9:0] other_food = '0;
    logic [3:0] snake_len = '0;
    logic [3:0] body_idx;
    logic [9:0] body_pos;
    logic       busy;
    logic       food_valid;
    logic [9:0] food_pos;

    logic [9:0] body [0:15];
    int n_checks = 0;
    int n_errors = 0;
    int cyc;
    int seen;

    always #5 clk = ~clk;

    assign body_pos = body[body_idx];

    food_placer #(
        .max_len(16), .num_len(10), .max_len_bit_len(4),
        .CELL_COUNT(1000), .INIT_FOOD(10'd300), .MAX_TRIES(4)
    ) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .rand_in(rand_in),
        .other_food(other_food), .snake_len(snake_len),
        .body_idx(body_idx), .body_pos(body_pos), .busy(busy),
        .food_valid(food_valid), .food_pos(food_pos)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_body(input int a, input int b, input int c);
        for (int i = 0; i < 16; i++) body[i] = 10'd900;
        body[0] = 10'(a);
        body[1] = 10'(b);
        body[2] = 10'(c);
    endtask

    // req is sampled at the next edge; returns just after it (count = 1)
    task automatic pulse_req();
        req = 1'b1;
        tick();
        req = 1'b0;
    endtask

    task automatic wait_valid(input int start, output int n);
        n = start;
        while (!food_valid && n < 400) begin
            tick();
            n++;
        end
    endtask

    initial begin
        set_body(1, 2, 3);
        #12;
        check("reset_food_pos", food_pos, 300);
        check("reset_food_valid", food_valid, 0);
        check("reset_busy", busy, 0);
        check("reset_body_idx", body_idx, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // clean placement
        snake_len = 4'd3; other_food = 10'd7; rand_in = 10'd5;
        pulse_req();
        check("clean_busy", busy, 1);
        wait_valid(1, cyc);
        check("clean_latency", cyc, 5);
        check("clean_food_pos", food_pos, 5);
        tick();
        check("clean_valid_pulse", food_valid, 0);
        check("clean_idle", busy, 0);

        // body hit with ignored mid-request req
        rand_in = 10'd2;
        pulse_req();
        tick();
        rand_in = 10'd9;
        check("hit_idx0", body_idx, 0);
        tick();
        check("hit_idx1", body_idx, 1);
        check("hit_food_hold", food_pos, 5);
        req = 1'b1;
        tick();
        req = 1'b0;
        check("hit_redraw_idx", body_idx, 0);
        check("hit_redraw_busy", busy, 1);
        wait_valid(4, cyc);
        check("hit_latency", cyc, 8);
        check("hit_food_pos", food_pos, 9);
        tick();
        check("hit_no_queue_a", busy, 0);
        tick();
        check("hit_no_queue_b", busy, 0);

        // invalid draws: off-grid then other_food
        rand_in = 10'd1000;
        pulse_req();
        tick();
        rand_in = 10'd7;
        check("inv_stay_idx", body_idx, 0);
        tick();
        rand_in = 10'd12;
        check("inv_stay_idx2", body_idx, 0);
        wait_valid(3, cyc);
        check("inv_latency", cyc, 7);
        check("inv_food_pos", food_pos, 12);
        tick();

        // zero-length body, top valid cell
        snake_len = 4'd0; rand_in = 10'd999;
        pulse_req();
        wait_valid(1, cyc);
        check("len0_latency", cyc, 2);
        check("len0_food_pos", food_pos, 999);
        tick();

        // reset during SCAN
        snake_len = 4'd3; rand_in = 10'd5;
        pulse_req();
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        check("rst_mid_busy", busy, 0);
        check("rst_mid_food_pos", food_pos, 300);
        check("rst_mid_valid", food_valid, 0);
        tick();
        check("rst_hold_valid", food_valid, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        pulse_req();
        wait_valid(1, cyc);
        check("rst_after_latency", cyc, 5);
        check("rst_after_food_pos", food_pos, 5);
        tick();

        // stuck LFSR on the only body cell
        set_body(2, 900, 900);
        snake_len = 4'd1; rand_in = 10'd2;
        pulse_req();
`ifdef FOOD_PLACER_PROBE_EN
        wait_valid(1, cyc);
        check("probe_latency", cyc, 11);
        check("probe_food_pos", food_pos, 3);
`else
        seen = 0;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (food_valid) seen++;
        end
        check("stuck_busy", busy, 1);
        check("stuck_no_valid", seen, 0);
        check("stuck_food_hold", food_pos, 5);
`endif

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
